// File: rtl/lock_status_display.sv
// Front-panel status controller for the password lock: result indication with
// self-generated blink rates, failure counting and a latched blocked state.
module lock_status_display #(
    parameter int CLK_HZ       = 50_000_000,
    parameter int FAST_HZ      = 5,
    parameter int SLOW_HZ      = 1,
    parameter int SHOW_SECONDS = 3,
    parameter int NUM_LEDR     = 18,
    parameter int NUM_LEDG     = 9,
    parameter int MAX_TRIALS   = 3
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic                mode,
    input  logic                new_input,
    input  logic                result_valid,
    input  logic [1:0]          result,
    input  logic                clear_block,
    output logic [NUM_LEDR-1:0] ledr,
    output logic [NUM_LEDG-1:0] ledg,
    output logic [6:0]          hex_mode,
    output logic [6:0]          hex_trials,
    output logic [6:0]          hex_msg1,
    output logic [6:0]          hex_msg0,
    output logic                blocked
);

    localparam int FAST_HALF = CLK_HZ / (2 * FAST_HZ);
    localparam int SLOW_HALF = CLK_HZ / (2 * SLOW_HZ);
    localparam int SHOW_CYC  = CLK_HZ * SHOW_SECONDS;
    localparam int FW        = $clog2(MAX_TRIALS + 1);
    localparam int TW        = $clog2(SHOW_CYC + 1);
    localparam int FCW       = $clog2(FAST_HALF + 1);
    localparam int SCW       = $clog2(SLOW_HALF + 1);

    localparam logic [6:0] SEG_OFF = 7'b1111111;
    localparam logic [6:0] SEG_S   = 7'b0010010;
    localparam logic [6:0] SEG_U   = 7'b1000001;
    localparam logic [6:0] SEG_C   = 7'b1000110;
    localparam logic [6:0] SEG_ALL = 7'b0000000;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SHOW_OK   = 3'd1,
        ST_SHOW_FAIL = 3'd2,
        ST_SHOW_SET  = 3'd3,
        ST_BLOCKED   = 3'd4
    } state_t;

    // Active-low seven-segment glyph for a decimal digit.
    function automatic logic [6:0] seg_digit(input logic [3:0] d);
        logic [6:0] g;
        case (d)
            4'd0:    g = 7'b1000000;
            4'd1:    g = 7'b1111001;
            4'd2:    g = 7'b0100100;
            4'd3:    g = 7'b0110000;
            4'd4:    g = 7'b0011001;
            4'd5:    g = 7'b0010010;
            4'd6:    g = 7'b0000010;
            4'd7:    g = 7'b1111000;
            4'd8:    g = 7'b0000000;
            4'd9:    g = 7'b0010000;
            default: g = 7'b1111111;
        endcase
        return g;
    endfunction

    state_t          state_r, state_s;
    logic [FW-1:0]   fail_cnt_r, fail_cnt_s, fail_inc_s;
    logic [TW-1:0]   show_timer_r;
    logic [FCW-1:0]  fast_cnt_r;
    logic [SCW-1:0]  slow_cnt_r;
    logic            fast_phase_r, slow_phase_r;
    logic            mode_q_r;
    logic            enter_show_s, in_show_s, show_done_s, restart_s;
    logic            rv_ok_s, rv_fail_s, rv_set_s;

    assign restart_s   = new_input | (mode != mode_q_r);
    assign rv_ok_s     = result_valid & mode & (result == 2'b00);
    assign rv_fail_s   = result_valid & mode & (result == 2'b01);
    assign rv_set_s    = result_valid & ~mode & (result == 2'b10);
    assign fail_inc_s  = fail_cnt_r + FW'(1);
    assign show_done_s = (show_timer_r >= TW'(SHOW_CYC - 1));

    // Classify the current state as one of the timed result indications.
    always_comb begin
        in_show_s = 1'b0;
        case (state_r)
            ST_SHOW_OK, ST_SHOW_FAIL, ST_SHOW_SET: in_show_s = 1'b1;
            default:                               in_show_s = 1'b0;
        endcase
    end

    // Next-state and failure-count logic, events resolved in priority order.
    always_comb begin
        state_s      = state_r;
        fail_cnt_s   = fail_cnt_r;
        enter_show_s = 1'b0;
        case (state_r)
            ST_IDLE, ST_SHOW_OK, ST_SHOW_FAIL, ST_SHOW_SET: begin
                if (clear_block) begin
                    fail_cnt_s = {FW{1'b0}};
                end else if (rv_ok_s) begin
                    state_s      = ST_SHOW_OK;
                    fail_cnt_s   = {FW{1'b0}};
                    enter_show_s = 1'b1;
                end else if (rv_fail_s) begin
                    if (fail_inc_s == FW'(MAX_TRIALS)) begin
                        state_s    = ST_BLOCKED;
                        fail_cnt_s = FW'(MAX_TRIALS);
                    end else begin
                        state_s      = ST_SHOW_FAIL;
                        fail_cnt_s   = fail_inc_s;
                        enter_show_s = 1'b1;
                    end
                end else if (rv_set_s) begin
                    state_s      = ST_SHOW_SET;
                    enter_show_s = 1'b1;
                end else if (restart_s) begin
                    state_s = ST_IDLE;
                end else if (in_show_s && show_done_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = state_r;
                end
            end
            ST_BLOCKED: begin
                if (clear_block) begin
                    state_s    = ST_IDLE;
                    fail_cnt_s = {FW{1'b0}};
                end else begin
                    state_s = ST_BLOCKED;
                end
            end
            default: begin
                state_s    = ST_IDLE;
                fail_cnt_s = {FW{1'b0}};
            end
        endcase
    end

    // State, failure count and mode history registers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_r    <= ST_IDLE;
            fail_cnt_r <= {FW{1'b0}};
            mode_q_r   <= 1'b0;
        end else begin
            state_r    <= state_s;
            fail_cnt_r <= fail_cnt_s;
            mode_q_r   <= mode;
        end
    end

    // Display hold timer; holds at its end value if a clear delays the exit.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            show_timer_r <= {TW{1'b0}};
        end else if (enter_show_s) begin
            show_timer_r <= {TW{1'b0}};
        end else if (in_show_s && !show_done_s) begin
            show_timer_r <= show_timer_r + TW'(1);
        end else if (in_show_s) begin
            show_timer_r <= show_timer_r;
        end else begin
            show_timer_r <= {TW{1'b0}};
        end
    end

    // Fast blink generator, restarted lit on every indication entry.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            fast_cnt_r   <= {FCW{1'b0}};
            fast_phase_r <= 1'b0;
        end else if (enter_show_s) begin
            fast_cnt_r   <= {FCW{1'b0}};
            fast_phase_r <= 1'b1;
        end else if (fast_cnt_r == FCW'(FAST_HALF - 1)) begin
            fast_cnt_r   <= {FCW{1'b0}};
            fast_phase_r <= ~fast_phase_r;
        end else begin
            fast_cnt_r   <= fast_cnt_r + FCW'(1);
        end
    end

    // Slow blink generator, restarted lit on every indication entry.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            slow_cnt_r   <= {SCW{1'b0}};
            slow_phase_r <= 1'b0;
        end else if (enter_show_s) begin
            slow_cnt_r   <= {SCW{1'b0}};
            slow_phase_r <= 1'b1;
        end else if (slow_cnt_r == SCW'(SLOW_HALF - 1)) begin
            slow_cnt_r   <= {SCW{1'b0}};
            slow_phase_r <= ~slow_phase_r;
        end else begin
            slow_cnt_r   <= slow_cnt_r + SCW'(1);
        end
    end

    // Indicator decode from registered state; only hex_mode sees an input.
    always_comb begin
        ledr       = {NUM_LEDR{1'b0}};
        ledg       = {NUM_LEDG{1'b0}};
        hex_msg1   = SEG_OFF;
        hex_msg0   = SEG_OFF;
        blocked    = 1'b0;
        hex_trials = seg_digit(4'(fail_cnt_r));
        case (state_r)
            ST_IDLE: begin
                ledr = {NUM_LEDR{1'b0}};
            end
            ST_SHOW_OK: begin
                ledg = {NUM_LEDG{fast_phase_r}};
            end
            ST_SHOW_FAIL: begin
                ledr = {NUM_LEDR{slow_phase_r}};
            end
            ST_SHOW_SET: begin
                hex_msg1 = SEG_S;
                hex_msg0 = SEG_U;
            end
            ST_BLOCKED: begin
                ledr    = {NUM_LEDR{1'b1}};
                ledg    = {NUM_LEDG{1'b1}};
                blocked = 1'b1;
            end
            default: begin
                ledr = {NUM_LEDR{1'b0}};
            end
        endcase
        if (state_r == ST_BLOCKED) begin
            hex_mode = SEG_ALL;
        end else if (mode) begin
            hex_mode = SEG_C;
        end else begin
            hex_mode = SEG_S;
        end
    end

endmodule

// File: tb/tb_lock_status_display.sv
// Directed bench for lock_status_display at a 100 Hz virtual clock so blink
// half-periods are 10/50 cycles and the display hold is 100 cycles.
module tb_lock_status_display;

    localparam int NR = 18;
    localparam int NG = 9;

    localparam logic [6:0] OFF  = 7'b1111111;
    localparam logic [6:0] G0   = 7'b1000000;
    localparam logic [6:0] G1   = 7'b1111001;
    localparam logic [6:0] G2   = 7'b0100100;
    localparam logic [6:0] G3   = 7'b0110000;
    localparam logic [6:0] GS   = 7'b0010010;
    localparam logic [6:0] GU   = 7'b1000001;
    localparam logic [6:0] GC   = 7'b1000110;
    localparam logic [6:0] GBLK = 7'b0000000;

    logic          clock = 1'b0;
    logic          resetn;
    logic          mode, new_input, result_valid, clear_block;
    logic [1:0]    result;
    logic [NR-1:0] ledr;
    logic [NG-1:0] ledg;
    logic [6:0]    hex_mode, hex_trials, hex_msg1, hex_msg0;
    logic          blocked;

    logic [NR-1:0] r_on;
    logic [NG-1:0] g_on;

    int errors = 0;
    int checks = 0;

    lock_status_display #(
        .CLK_HZ(100), .FAST_HZ(5), .SLOW_HZ(1), .SHOW_SECONDS(1),
        .NUM_LEDR(NR), .NUM_LEDG(NG), .MAX_TRIALS(3)
    ) dut (
        .clock(clock), .resetn(resetn), .mode(mode), .new_input(new_input),
        .result_valid(result_valid), .result(result), .clear_block(clear_block),
        .ledr(ledr), .ledg(ledg), .hex_mode(hex_mode), .hex_trials(hex_trials),
        .hex_msg1(hex_msg1), .hex_msg0(hex_msg0), .blocked(blocked)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_result(input logic [1:0] r);
        result       = r;
        result_valid = 1'b1;
        tick();
        result_valid = 1'b0;
        result       = 2'b11;
    endtask

    task automatic test_reset();
        resetn = 1'b0; mode = 1'b1; new_input = 1'b0;
        result_valid = 1'b0; result = 2'b11; clear_block = 1'b0;
        tick(); tick();
        checks++;
        if (ledr !== '0 || ledg !== '0) begin
            errors++; $display("FAIL reset_leds ledr=%b ledg=%b expected all zero", ledr, ledg);
        end
        resetn = 1'b1;
        tick(); tick();
        checks++;
        if (hex_msg1 !== OFF || hex_msg0 !== OFF) begin
            errors++; $display("FAIL reset_msgs got %b %b expected %b %b", hex_msg1, hex_msg0, OFF, OFF);
        end
        checks++;
        if (hex_trials !== G0) begin
            errors++; $display("FAIL reset_trials got %b expected %b", hex_trials, G0);
        end
        checks++;
        if (hex_mode !== GC || blocked !== 1'b0 || ledr !== '0 || ledg !== '0) begin
            errors++; $display("FAIL reset_idle hex_mode=%b blocked=%b ledr=%b ledg=%b expected %b 0 0 0",
                               hex_mode, blocked, ledr, ledg, GC);
        end
    endtask

    task automatic test_match_blink();
        logic [NG-1:0] exp_g;
        pulse_result(2'b00);
        for (int k = 0; k <= 100; k++) begin
            if (k < 100) exp_g = (((k / 10) % 2) == 0) ? g_on : '0;
            else         exp_g = '0;
            checks++;
            if (ledg !== exp_g) begin
                errors++; $display("FAIL match_blink k=%0d ledg=%b expected %b", k, ledg, exp_g);
            end
            if (k < 100) tick();
        end
        checks++;
        if (ledr !== '0 || hex_msg1 !== OFF) begin
            errors++; $display("FAIL match_other ledr=%b msg1=%b expected 0 %b", ledr, hex_msg1, OFF);
        end
    endtask

    task automatic test_block();
        logic [6:0] exp_t;
        for (int p = 1; p <= 2; p++) begin
            exp_t = (p == 1) ? G1 : G2;
            pulse_result(2'b01);
            for (int k = 0; k < 200; k++) begin
                if (k == 0 || k == 49) begin
                    checks++;
                    if (ledr !== r_on) begin
                        errors++; $display("FAIL fail_blink_on p=%0d k=%0d ledr=%b expected %b", p, k, ledr, r_on);
                    end
                end
                if (k == 50 || k == 99 || k == 100) begin
                    checks++;
                    if (ledr !== '0) begin
                        errors++; $display("FAIL fail_blink_off p=%0d k=%0d ledr=%b expected 0", p, k, ledr);
                    end
                end
                if (k == 0 || k == 150) begin
                    checks++;
                    if (hex_trials !== exp_t || blocked !== 1'b0) begin
                        errors++; $display("FAIL fail_trials p=%0d k=%0d got %b blocked=%b expected %b 0",
                                           p, k, hex_trials, blocked, exp_t);
                    end
                end
                tick();
            end
        end
        pulse_result(2'b01);
        checks++;
        if (blocked !== 1'b1 || ledr !== r_on || ledg !== g_on) begin
            errors++; $display("FAIL blocked_leds blocked=%b ledr=%b ledg=%b expected 1 all-ones", blocked, ledr, ledg);
        end
        checks++;
        if (hex_mode !== GBLK || hex_trials !== G3) begin
            errors++; $display("FAIL blocked_hex mode=%b trials=%b expected %b %b", hex_mode, hex_trials, GBLK, G3);
        end
        pulse_result(2'b00);
        tick(); tick();
        checks++;
        if (blocked !== 1'b1 || hex_trials !== G3 || ledr !== r_on) begin
            errors++; $display("FAIL blocked_ignores_match blocked=%b trials=%b expected 1 %b", blocked, hex_trials, G3);
        end
        clear_block = 1'b1;
        tick();
        clear_block = 1'b0;
        checks++;
        if (blocked !== 1'b0 || hex_trials !== G0 || ledr !== '0 || ledg !== '0 || hex_mode !== GC) begin
            errors++; $display("FAIL block_clear blocked=%b trials=%b ledr=%b ledg=%b expected 0 %b 0 0",
                               blocked, hex_trials, ledr, ledg, G0);
        end
    endtask

    task automatic test_back_to_back();
        pulse_result(2'b01);
        pulse_result(2'b01);
        checks++;
        if (hex_trials !== G2 || ledr !== r_on) begin
            errors++; $display("FAIL b2b_two_fail trials=%b ledr=%b expected %b all-ones", hex_trials, ledr, G2);
        end
        pulse_result(2'b00);
        checks++;
        if (hex_trials !== G0 || ledg !== g_on || ledr !== '0) begin
            errors++; $display("FAIL b2b_match trials=%b ledg=%b ledr=%b expected %b all-ones 0",
                               hex_trials, ledg, ledr, G0);
        end
        pulse_result(2'b01);
        checks++;
        if (hex_trials !== G1 || blocked !== 1'b0 || ledr !== r_on) begin
            errors++; $display("FAIL b2b_single_fail trials=%b blocked=%b expected %b 0", hex_trials, blocked, G1);
        end
        for (int k = 0; k < 101; k++) tick();
        clear_block = 1'b1;
        tick();
        clear_block = 1'b0;
        checks++;
        if (hex_trials !== G0 || ledr !== '0 || blocked !== 1'b0) begin
            errors++; $display("FAIL idle_clear trials=%b ledr=%b expected %b 0", hex_trials, ledr, G0);
        end
    endtask

    task automatic test_set_display();
        mode = 1'b0;
        tick(); tick();
        pulse_result(2'b10);
        checks++;
        if (hex_msg1 !== GS || hex_msg0 !== GU || ledr !== '0 || ledg !== '0 || hex_mode !== GS) begin
            errors++; $display("FAIL set_show msg1=%b msg0=%b mode=%b expected %b %b %b",
                               hex_msg1, hex_msg0, hex_mode, GS, GU, GS);
        end
        for (int k = 0; k < 30; k++) tick();
        checks++;
        if (hex_msg1 !== GS || hex_msg0 !== GU) begin
            errors++; $display("FAIL set_hold msg1=%b msg0=%b expected %b %b", hex_msg1, hex_msg0, GS, GU);
        end
        new_input = 1'b1;
        tick();
        new_input = 1'b0;
        checks++;
        if (hex_msg1 !== OFF || hex_msg0 !== OFF) begin
            errors++; $display("FAIL set_new_input msg1=%b msg0=%b expected off", hex_msg1, hex_msg0);
        end
        pulse_result(2'b10);
        tick();
        checks++;
        if (hex_msg1 !== GS || hex_msg0 !== GU) begin
            errors++; $display("FAIL set_reshow msg1=%b msg0=%b expected %b %b", hex_msg1, hex_msg0, GS, GU);
        end
        mode = 1'b1;
        #1;
        checks++;
        if (hex_mode !== GC || hex_msg1 !== GS) begin
            errors++; $display("FAIL set_mode_glyph mode=%b msg1=%b expected %b %b", hex_mode, hex_msg1, GC, GS);
        end
        tick();
        checks++;
        if (hex_msg1 !== OFF || hex_msg0 !== OFF) begin
            errors++; $display("FAIL set_mode_toggle msg1=%b msg0=%b expected off", hex_msg1, hex_msg0);
        end
    endtask

    task automatic test_clear_priority();
        pulse_result(2'b01);
        pulse_result(2'b01);
        pulse_result(2'b01);
        checks++;
        if (blocked !== 1'b1) begin
            errors++; $display("FAIL prio_setup blocked=%b expected 1", blocked);
        end
        clear_block  = 1'b1;
        result       = 2'b01;
        result_valid = 1'b1;
        tick();
        clear_block  = 1'b0;
        result_valid = 1'b0;
        result       = 2'b11;
        checks++;
        if (blocked !== 1'b0 || hex_trials !== G0 || ledr !== '0 || ledg !== '0) begin
            errors++; $display("FAIL prio_clear_wins blocked=%b trials=%b ledr=%b expected 0 %b 0",
                               blocked, hex_trials, ledr, G0);
        end
    endtask

    task automatic test_async_reset();
        pulse_result(2'b01);
        for (int k = 0; k < 5; k++) tick();
        checks++;
        if (ledr !== r_on || hex_trials !== G1) begin
            errors++; $display("FAIL areset_setup ledr=%b trials=%b expected all-ones %b", ledr, hex_trials, G1);
        end
        #2;
        resetn = 1'b0;
        #1;
        checks++;
        if (ledr !== '0 || hex_trials !== G0 || blocked !== 1'b0) begin
            errors++; $display("FAIL areset_immediate ledr=%b trials=%b expected 0 %b", ledr, hex_trials, G0);
        end
        tick();
        resetn = 1'b1;
        tick(); tick();
        checks++;
        if (ledr !== '0 || hex_trials !== G0 || hex_msg1 !== OFF) begin
            errors++; $display("FAIL areset_release ledr=%b trials=%b expected 0 %b", ledr, hex_trials, G0);
        end
    endtask

    initial begin
        r_on = '1;
        g_on = '1;
        test_reset();
        test_match_blink();
        test_block();
        test_back_to_back();
        test_set_display();
        test_clear_priority();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
